// File: rtl/keycode_dir_filter_if.sv
// Bus between the keycode source/game logic (master) and keycode_dir_filter (slave).
interface keycode_dir_filter_if;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       turn_ack;
  logic [1:0] pend_dir;
  logic       pend_valid;
  logic       paused;

  modport master (
    output keycode, frame_tick, turn_ack,
    input  pend_dir, pend_valid, paused
  );

  modport slave (
    input  keycode, frame_tick, turn_ack,
    output pend_dir, pend_valid, paused
  );
endinterface

// File: rtl/keycode_dir_filter.sv
// Debounces HID keycodes into one-shot direction requests with frame-based expiry.
// Optional pause toggle on space (0x2C) when KEYCODE_PAUSE_EN is defined.
module keycode_dir_filter #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned PEND_FRAMES   = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  keycode_dir_filter_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax   = CntW'(STABLE_CYCLES - 1);
  localparam logic [7:0]      FrameMax = 8'(PEND_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StFilter, StLatched} state_e;

  state_e          state_q, state_d;
  logic [7:0]      k_q;
  logic            k_chg_q;
  logic [CntW-1:0] stab_cnt_q, stab_cnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [1:0]      pend_dir_q, pend_dir_d;
  logic            pend_valid_q, pend_valid_d;

  logic       is_dir, is_space, mapped, stable_hit, load, expire, pause_set, paused;
  logic [1:0] dir;

  always_comb begin
    is_dir = 1'b1;
    dir    = 2'd0;
    case (k_q)
      8'h1A, 8'h52: dir = 2'd0;
      8'h04, 8'h50: dir = 2'd1;
      8'h16, 8'h51: dir = 2'd2;
      8'h07, 8'h4F: dir = 2'd3;
      default:      is_dir = 1'b0;
    endcase
  end

`ifdef KEYCODE_PAUSE_EN
  logic paused_q, toggle;

  assign is_space  = (k_q == 8'h2C);
  assign toggle    = stable_hit && is_space;
  assign pause_set = toggle && !paused_q;
  assign paused    = paused_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) paused_q <= 1'b0;
    else          paused_q <= paused_q ^ toggle;
  end
`else
  assign is_space  = 1'b0;
  assign pause_set = 1'b0;
  assign paused    = 1'b0;
`endif

  assign mapped     = is_dir || is_space;
  assign stable_hit = (state_q == StFilter) && (stab_cnt_q == CntMax);
  assign load       = stable_hit && is_dir && !paused;
  assign expire     = pend_valid_q && bus.frame_tick && (frame_cnt_q == FrameMax);

  always_comb begin
    state_d = state_q;
    if (!mapped)                            state_d = StIdle;
    else if (k_chg_q || state_q == StIdle)  state_d = StFilter;
    else if (stable_hit)                    state_d = StLatched;
  end

  always_comb begin
    // Counter is already 0 in the first cycle k_q holds a new code.
    if (bus.keycode != k_q)     stab_cnt_d = '0;
    else if (stab_cnt_q == CntMax) stab_cnt_d = stab_cnt_q;
    else                        stab_cnt_d = stab_cnt_q + CntW'(1);

    pend_dir_d   = load ? dir : pend_dir_q;
    pend_valid_d = pend_valid_q;
    if (load)                                                    pend_valid_d = 1'b1;
    else if ((bus.turn_ack && pend_valid_q) || expire || pause_set) pend_valid_d = 1'b0;

    if (load || !pend_valid_d) frame_cnt_d = '0;
    else                       frame_cnt_d = frame_cnt_q + {7'd0, bus.frame_tick};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      k_q          <= 8'h00;
      k_chg_q      <= 1'b0;
      stab_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      pend_dir_q   <= 2'd0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= bus.keycode;
      k_chg_q      <= (bus.keycode != k_q);
      stab_cnt_q   <= stab_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign bus.pend_dir   = pend_dir_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.paused     = paused;

endmodule

// File: tb/tb_keycode_dir_filter.sv
// Directed bench for keycode_dir_filter; pause scenario built only with KEYCODE_PAUSE_EN.
module tb_keycode_dir_filter;
  logic clk = 1'b0;
  logic reset_n;
  int   passed = 0;
  int   total  = 0;

  keycode_dir_filter_if bus ();

  keycode_dir_filter #(
    .STABLE_CYCLES(16),
    .PEND_FRAMES  (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_key(input logic [7:0] code, input int n);
    bus.keycode = code;
    step(n);
  endtask

  task automatic ack_once();
    bus.turn_ack = 1'b1;
    step(1);
    bus.turn_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.keycode = 8'h00; bus.frame_tick = 1'b0; bus.turn_ack = 1'b0;
    step(2);
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.pend_valid); else passed++;
    total++; if (bus.pend_dir !== 2'd0) $display("FAIL reset_dir: got %0d want 0", bus.pend_dir); else passed++;
    total++; if (bus.paused !== 1'b0) $display("FAIL reset_paused: got %0b want 0", bus.paused); else passed++;
    reset_n = 1'b1;
    step(2);
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL post_reset_valid: got %0b want 0", bus.pend_valid); else passed++;
  endtask

  task automatic test_hold();
    bus.keycode = 8'h1A;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      total++;
      if (bus.pend_valid !== (i >= 17))
        $display("FAIL hold_valid step %0d: got %0b want %0b", i, bus.pend_valid, (i >= 17));
      else passed++;
    end
    total++; if (bus.pend_dir !== 2'd0) $display("FAIL hold_dir: got %0d want 0", bus.pend_dir); else passed++;
    ack_once();
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL hold_ack: got %0b want 0", bus.pend_valid); else passed++;
    step(5);
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL hold_single: got %0b want 0", bus.pend_valid); else passed++;
    hold_key(8'h00, 2);
  endtask

  task automatic test_change();
    bus.keycode = 8'h04;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      total++;
      if (bus.pend_valid !== 1'b0) $display("FAIL change_left step %0d: got %0b want 0", i, bus.pend_valid);
      else passed++;
    end
    bus.keycode = 8'h07;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      total++;
      if (bus.pend_valid !== (i >= 17))
        $display("FAIL change_right step %0d: got %0b want %0b", i, bus.pend_valid, (i >= 17));
      else passed++;
    end
    total++; if (bus.pend_dir !== 2'd3) $display("FAIL change_dir: got %0d want 3", bus.pend_dir); else passed++;
    bus.keycode = 8'h00;
    ack_once();
    step(2);
  endtask

  task automatic test_expiry();
    hold_key(8'h50, 17);
    total++; if (bus.pend_valid !== 1'b1) $display("FAIL exp_setup_valid: got %0b want 1", bus.pend_valid); else passed++;
    total++; if (bus.pend_dir !== 2'd1) $display("FAIL exp_setup_dir: got %0d want 1", bus.pend_dir); else passed++;
    bus.keycode = 8'h00;
    for (int p = 1; p <= 8; p++) begin
      bus.frame_tick = 1'b1;
      step(1);
      bus.frame_tick = 1'b0;
      total++;
      if (bus.pend_valid !== (p < 8))
        $display("FAIL expire pulse %0d: got %0b want %0b", p, bus.pend_valid, (p < 8));
      else passed++;
      step(2);
    end
    hold_key(8'h51, 17);
    total++; if (bus.pend_valid !== 1'b1) $display("FAIL ackfr_setup: got %0b want 1", bus.pend_valid); else passed++;
    bus.keycode = 8'h00;
    for (int p = 1; p <= 3; p++) begin
      bus.frame_tick = 1'b1;
      bus.turn_ack   = (p == 3);
      step(1);
      bus.frame_tick = 1'b0;
      bus.turn_ack   = 1'b0;
      total++;
      if (bus.pend_valid !== (p < 3))
        $display("FAIL ack_pulse %0d: got %0b want %0b", p, bus.pend_valid, (p < 3));
      else passed++;
      step(1);
    end
    total++; if (bus.pend_dir !== 2'd2) $display("FAIL dir_retained: got %0d want 2", bus.pend_dir); else passed++;
  endtask

  task automatic test_load_ack();
    hold_key(8'h4F, 17);
    total++; if (bus.pend_dir !== 2'd3) $display("FAIL la_setup_dir: got %0d want 3", bus.pend_dir); else passed++;
    hold_key(8'h1A, 16);
    total++; if (bus.pend_valid !== 1'b1) $display("FAIL la_pre_valid: got %0b want 1", bus.pend_valid); else passed++;
    total++; if (bus.pend_dir !== 2'd3) $display("FAIL la_pre_dir: got %0d want 3", bus.pend_dir); else passed++;
    ack_once();
    total++; if (bus.pend_valid !== 1'b1) $display("FAIL la_valid: got %0b want 1", bus.pend_valid); else passed++;
    total++; if (bus.pend_dir !== 2'd0) $display("FAIL la_dir: got %0d want 0", bus.pend_dir); else passed++;
    ack_once();
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL la_clear: got %0b want 0", bus.pend_valid); else passed++;
    hold_key(8'h00, 2);
  endtask

`ifdef KEYCODE_PAUSE_EN
  task automatic test_pause();
    hold_key(8'h1A, 17);
    hold_key(8'h00, 1);
    hold_key(8'h2C, 16);
    total++; if (bus.paused !== 1'b0) $display("FAIL pause_pre: got %0b want 0", bus.paused); else passed++;
    total++; if (bus.pend_valid !== 1'b1) $display("FAIL pause_pre_valid: got %0b want 1", bus.pend_valid); else passed++;
    step(1);
    total++; if (bus.paused !== 1'b1) $display("FAIL pause_set: got %0b want 1", bus.paused); else passed++;
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL pause_clear: got %0b want 0", bus.pend_valid); else passed++;
    step(3);
    total++; if (bus.paused !== 1'b1) $display("FAIL pause_once: got %0b want 1", bus.paused); else passed++;
    hold_key(8'h00, 2);
    hold_key(8'h51, 20);
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL pause_noload: got %0b want 0", bus.pend_valid); else passed++;
    hold_key(8'h00, 2);
    hold_key(8'h2C, 17);
    total++; if (bus.paused !== 1'b0) $display("FAIL unpause: got %0b want 0", bus.paused); else passed++;
    hold_key(8'h00, 2);
  endtask
`else
  task automatic test_space_unmapped();
    hold_key(8'h16, 17);
    hold_key(8'h2C, 20);
    total++; if (bus.paused !== 1'b0) $display("FAIL space_paused: got %0b want 0", bus.paused); else passed++;
    total++; if (bus.pend_valid !== 1'b1) $display("FAIL space_keeps: got %0b want 1", bus.pend_valid); else passed++;
    total++; if (bus.pend_dir !== 2'd2) $display("FAIL space_dir: got %0d want 2", bus.pend_dir); else passed++;
    bus.keycode = 8'h00;
    ack_once();
    step(2);
  endtask
`endif

  task automatic test_reset_mid();
    hold_key(8'h07, 17);
    total++; if (bus.pend_dir !== 2'd3) $display("FAIL rm_setup_dir: got %0d want 3", bus.pend_dir); else passed++;
    hold_key(8'h00, 1);
    hold_key(8'h16, 11);
    reset_n = 1'b0;
    #1;
    total++; if (bus.pend_valid !== 1'b0) $display("FAIL rm_valid: got %0b want 0", bus.pend_valid); else passed++;
    total++; if (bus.pend_dir !== 2'd0) $display("FAIL rm_dir: got %0d want 0", bus.pend_dir); else passed++;
    total++; if (bus.paused !== 1'b0) $display("FAIL rm_paused: got %0b want 0", bus.paused); else passed++;
    #2;
    reset_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      total++;
      if (bus.pend_valid !== (i >= 17))
        $display("FAIL rm_reload step %0d: got %0b want %0b", i, bus.pend_valid, (i >= 17));
      else passed++;
    end
    total++; if (bus.pend_dir !== 2'd2) $display("FAIL rm_reload_dir: got %0d want 2", bus.pend_dir); else passed++;
    bus.keycode = 8'h00;
    ack_once();
    step(2);
  endtask

  initial begin
    test_reset();
    test_hold();
    test_change();
    test_expiry();
    test_load_ack();
`ifdef KEYCODE_PAUSE_EN
    test_pause();
`else
    test_space_unmapped();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/keycode_dir_filter.md
KEYCODE_DIR_FILTER -- requirements
Module: keycode_dir_filter

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: cycles a keycode must be held unchanged before it is accepted; legal range 2..65535.
REQ-002 SHALL have parameter PEND_FRAMES, default 8: frame_tick pulses an unacknowledged turn request survives; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port keycode, input, 8 bits: USB HID keycode from the keycode PIO out_port; 0x00 means no key.
REQ-006 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-007 SHALL have port turn_ack, input, 1 bit: game logic consumed the pending turn.
REQ-008 SHALL have port pend_dir, output, 2 bits: requested direction (0 up, 1 left, 2 down, 3 right).
REQ-009 SHALL have port pend_valid, output, 1 bit: pend_dir holds an unconsumed request.
REQ-010 SHALL have port paused, output, 1 bit: game pause state.

Function
REQ-011 SHALL register keycode into k_q every cycle; all decoding uses k_q (one-cycle input latency).
REQ-012 SHALL map 0x1A/0x52 to up, 0x04/0x50 to left, 0x16/0x51 to down, 0x07/0x4F to right; every other code is unmapped.
REQ-013 SHALL keep a stability counter that clears to 0 when k_q differs from its previous value, otherwise increments, saturating at STABLE_CYCLES-1.
REQ-014 SHALL implement FSM states IDLE, FILTER, LATCHED.
REQ-015 IDLE -> FILTER when k_q is mapped (or is 0x2C with pause enabled); FILTER/LATCHED -> IDLE when k_q becomes unmapped; any k_q change from FILTER or LATCHED restarts FILTER with the counter cleared.
REQ-016 FILTER -> LATCHED in the cycle the counter equals STABLE_CYCLES-1; in that same cycle, when the key is a direction and paused is 0, pend_dir SHALL load the direction and pend_valid SHALL be set on the next edge.
REQ-017 LATCHED SHALL NOT reload; holding a key produces exactly one request until the keycode changes.
REQ-018 turn_ack while pend_valid=1 SHALL clear pend_valid next cycle; turn_ack while pend_valid=0 SHALL be ignored.
REQ-019 Simultaneous load and turn_ack: load wins; pend_valid stays 1 with the new pend_dir.
REQ-020 A new load while pend_valid=1 SHALL overwrite pend_dir and restart the frame counter.
REQ-021 SHALL count frame_tick pulses while pend_valid=1; when the count reaches PEND_FRAMES, pend_valid clears on that edge unless a load occurs in the same cycle (load wins); turn_ack and expiry in the same cycle both clear.
REQ-022 Frame counter SHALL clear whenever pend_valid is 0.
REQ-023 pend_dir SHALL retain its last value when pend_valid is 0.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, k_q=0x00, counters 0, pend_dir=0, pend_valid=0, paused=0.
REQ-025 Reset asserted mid-filter or with a pending request SHALL discard it; after release, a still-held key SHALL require a full STABLE_CYCLES+1 cycles before loading.

Configuration
REQ-026 Macro KEYCODE_PAUSE_EN defined: 0x2C (space) passes through IDLE/FILTER/LATCHED like a direction key; reaching LATCHED toggles paused once per press; toggling to 1 SHALL clear pend_valid; no direction loads while paused=1.
REQ-027 Macro KEYCODE_PAUSE_EN undefined: 0x2C is unmapped, paused is tied to 0, no pause logic synthesized.

Verification
REQ-028 Hold keycode 0x1A for 20 cycles -> pend_valid rises exactly 17 cycles after keycode applied, pend_dir=0, one request only.
REQ-029 Apply 0x04 for 10 cycles then 0x07 for 20 -> no load for 0x04; single load with pend_dir=3.
REQ-030 Valid request, no turn_ack, 8 frame_tick pulses -> pend_valid clears on the 8th pulse edge; with turn_ack on 3rd pulse -> clears then.
REQ-031 New load cycle coincident with turn_ack -> pend_valid remains 1, pend_dir updated.
REQ-032 KEYCODE_PAUSE_EN defined: hold 0x2C 20 cycles with pending request -> paused=1, pend_valid=0; then 0x51 held -> no load; release, press 0x2C again -> paused=0.
REQ-033 Pull reset_n low at counter=10 with 0x16 held, release -> all outputs 0 immediately, load occurs 17 cycles after release.
